id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
// ID/EX pipeline register for the RV32I 5-stage core, with integrated load-use hazard detection.
// Captures decoded operands and control from ID and presents them to EX (ALU control, ALU, branch unit).
// Inserts bubbles on load-use hazards and branch/jump flushes, freezes on a global hold,
// and keeps saturating stall/flush event counters for debug.
// PARAMETERS
// XLEN   32  datapath width
// CNT_W  16  width of the saturating event counters
// PORTS
// clk             in   1      core clock, all state on rising edge
// rst_n           in   1      synchronous, active-low reset
// hold            in   1      global freeze (memory wait); EX contents held
// flush           in   1      branch/jump taken in EX; kill the instruction entering EX
// id_valid        in   1      ID slot holds a real instruction
// id_pc           in   XLEN   PC of the ID instruction
// id_rs1_data     in   XLEN   register file read port 1
// id_rs2_data     in   XLEN   register file read port 2
// id_imm          in   XLEN   sign-extended immediate
// id_rs1, id_rs2  in   5      source register indices
// id_uses_rs1/2   in   1      the instruction reads rs1/rs2
// id_rd           in   5      destination index
// id_funct3       in   3      instr[14:12]
// id_funct7_5     in   1      instr[30]
// id_alu_op       in   2      alu_op_t from the main decoder
// id_ctrl         in   ex_ctrl_t  {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump}
// ex_valid        out  1      EX slot holds a real instruction
// ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies
// ex_rs1, ex_rs2, ex_rd       out  5  registered indices (used by forwarding)
// ex_funct3 / ex_funct7_5 / ex_alu_op  out  3/1/2  registered; drive ALU control
// ex_ctrl         out  ex_ctrl_t  registered control
// load_use_stall  out  1      combinational; hold PC and IF/ID this cycle
// stall_cnt       out  CNT_W  count of bubbles inserted for load-use
// flush_cnt       out  CNT_W  count of flush-induced bubbles
// BEHAVIOUR
// - Reset (rst_n=0 at edge): every registered output is 0, including both counters; ex_alu_op = ALU_OP_ADD (2'b00).
// - Hazard (combinational): haz = ex_valid & ex_ctrl.mem_read & ex_rd!=0 & id_valid
//   & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
// - load_use_stall = haz & ~flush. A killed ID instruction never stalls.
// - Per-edge priority is rst_n=0 > hold > flush > haz > load:
//   - hold: all EX registers and counters keep their values. load_use_stall still reflects haz.
//   - flush: bubble enters EX; flush_cnt += 1.
//   - haz: bubble enters EX; stall_cnt += 1. ID is re-presented next cycle by the upstream hold.
//   - load: every ex_* field <= id_* field, and ex_valid <= id_valid.
// - Bubble: ex_valid=0, ex_ctrl all 0 (no reg/mem write, no branch/jump), ex_alu_op=ALU_OP_ADD, all data/index fields 0.
// - Latency: 1 cycle ID->EX. A load-use hazard costs exactly 1 bubble; haz deasserts once the load leaves EX.
// - Counters saturate at 2^CNT_W-1 and do not wrap.
// - If id_valid=0 on a load, ex_valid=0, but the other fields still load. Consumers qualify everything with ex_valid.
// - rs/rd index 0 never raises a hazard.
// STRUCTURE
// - riscv_pkg: alu_op_t (ALU_OP_ADD=2'b00, ALU_OP_BRANCH=2'b01, ALU_OP_RTYPE=2'b10), ex_ctrl_t packed struct, XLEN default.
// - Sub-module load_use_detect: purely combinational haz/load_use_stall logic, unit-testable.
// - Top level: one register bank with bubble mux, plus two saturating counters.
// TESTING
// 1. rst_n=0 for 2 cycles with random id_* inputs -> all outputs 0, counters 0, load_use_stall=0.
// 2. ADD x3,x1,x2 (alu_op=10, funct3=000, funct7_5=0), id_valid=1 -> next cycle ex_rd=3, ex_alu_op=10, ex_valid=1.
// 3. LW x5 in EX, then ADD x6,x5,x1 in ID -> load_use_stall=1 for 1 cycle; then a bubble in EX with ex_ctrl=0;
//    stall_cnt=1; the ADD enters EX on the following cycle.
// 4. Same as 3 but rd=x0, or uses_rs1=0 -> no stall; stall_cnt unchanged.
// 5. flush=1 while haz=1 -> load_use_stall=0, bubble in EX, flush_cnt=1, stall_cnt=0.
// 6. hold=1 for 3 cycles with flush=1 and new ID data -> EX fields and counters frozen.
//    Release hold -> the flush takes effect on the first free edge.
//    Preload stall_cnt to 0xFFFF and force a hazard -> stall_cnt stays 0xFFFF.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the RV32I 5-stage core: ALU operation class and the
// EX-stage control bundle produced by the main decoder.
package riscv_pkg;

  localparam int DEFAULT_XLEN = 32;

  typedef enum logic [1:0] {
    ALU_OP_ADD    = 2'b00,
    ALU_OP_BRANCH = 2'b01,
    ALU_OP_RTYPE  = 2'b10
  } alu_op_t;

  // MSB first: alu_src is bit 6, jump is bit 0
  typedef struct packed {
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
    logic branch;
    logic jump;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_NONE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load sitting in EX and
// the instruction in ID; a flushed ID instruction never requests a stall.
module load_use_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       flush,
  output logic       haz,
  output logic       load_use_stall
);

  logic ex_is_load;
  logic rs1_match;
  logic rs2_match;

  always_comb begin
    ex_is_load     = ex_valid & ex_mem_read & (ex_rd != 5'd0);
    rs1_match      = id_uses_rs1 & (id_rs1 == ex_rd);
    rs2_match      = id_uses_rs2 & (id_rs2 == ex_rd);
    haz            = ex_is_load & id_valid & (rs1_match | rs2_match);
    load_use_stall = haz & ~flush;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush bubbles,
// global hold, and saturating stall/flush event counters.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [4:0]        id_rd,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7_5,
  input  logic [1:0]        id_alu_op,
  input  ex_ctrl_t          id_ctrl,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7_5,
  output logic [1:0]        ex_alu_op,
  output ex_ctrl_t          ex_ctrl,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              ex_valid_q,    ex_valid_d;
  logic [XLEN-1:0]   ex_pc_q,       ex_pc_d;
  logic [XLEN-1:0]   ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0]   ex_rs2_data_q, ex_rs2_data_d;
  logic [XLEN-1:0]   ex_imm_q,      ex_imm_d;
  logic [4:0]        ex_rs1_q,      ex_rs1_d;
  logic [4:0]        ex_rs2_q,      ex_rs2_d;
  logic [4:0]        ex_rd_q,       ex_rd_d;
  logic [2:0]        ex_funct3_q,   ex_funct3_d;
  logic              ex_funct7_5_q, ex_funct7_5_d;
  logic [1:0]        ex_alu_op_q,   ex_alu_op_d;
  ex_ctrl_t          ex_ctrl_q,     ex_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q,   stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q,   flush_cnt_d;

  logic haz;

  load_use_detect u_load_use_detect (
    .ex_valid       (ex_valid_q),
    .ex_mem_read    (ex_ctrl_q.mem_read),
    .ex_rd          (ex_rd_q),
    .id_valid       (id_valid),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .flush          (flush),
    .haz            (haz),
    .load_use_stall (load_use_stall)
  );

  // Priority hold > flush > hazard > load; flush and hazard both insert a bubble
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_imm_d      = ex_imm_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_rd_d       = ex_rd_q;
    ex_funct3_d   = ex_funct3_q;
    ex_funct7_5_d = ex_funct7_5_q;
    ex_alu_op_d   = ex_alu_op_q;
    ex_ctrl_d     = ex_ctrl_q;
    if (!hold) begin
      if (flush || haz) begin
        ex_valid_d    = 1'b0;
        ex_pc_d       = '0;
        ex_rs1_data_d = '0;
        ex_rs2_data_d = '0;
        ex_imm_d      = '0;
        ex_rs1_d      = '0;
        ex_rs2_d      = '0;
        ex_rd_d       = '0;
        ex_funct3_d   = '0;
        ex_funct7_5_d = 1'b0;
        ex_alu_op_d   = ALU_OP_ADD;
        ex_ctrl_d     = EX_CTRL_NONE;
      end else begin
        ex_valid_d    = id_valid;
        ex_pc_d       = id_pc;
        ex_rs1_data_d = id_rs1_data;
        ex_rs2_data_d = id_rs2_data;
        ex_imm_d      = id_imm;
        ex_rs1_d      = id_rs1;
        ex_rs2_d      = id_rs2;
        ex_rd_d       = id_rd;
        ex_funct3_d   = id_funct3;
        ex_funct7_5_d = id_funct7_5;
        ex_alu_op_d   = id_alu_op;
        ex_ctrl_d     = id_ctrl;
      end
    end
  end

  // Event counters stick at all-ones instead of wrapping
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!hold) begin
      if (flush) begin
        if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else if (haz) begin
        if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_funct3_q   <= '0;
      ex_funct7_5_q <= 1'b0;
      ex_alu_op_q   <= ALU_OP_ADD;
      ex_ctrl_q     <= EX_CTRL_NONE;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_funct3_q   <= ex_funct3_d;
      ex_funct7_5_q <= ex_funct7_5_d;
      ex_alu_op_q   <= ex_alu_op_d;
      ex_ctrl_q     <= ex_ctrl_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  always_comb begin
    ex_valid    = ex_valid_q;
    ex_pc       = ex_pc_q;
    ex_rs1_data = ex_rs1_data_q;
    ex_rs2_data = ex_rs2_data_q;
    ex_imm      = ex_imm_q;
    ex_rs1      = ex_rs1_q;
    ex_rs2      = ex_rs2_q;
    ex_rd       = ex_rd_q;
    ex_funct3   = ex_funct3_q;
    ex_funct7_5 = ex_funct7_5_q;
    ex_alu_op   = ex_alu_op_q;
    ex_ctrl     = ex_ctrl_q;
    stall_cnt   = stall_cnt_q;
    flush_cnt   = flush_cnt_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a table of per-cycle ID inputs with the
// expected EX contents, plus counter saturation on a narrow-counter instance.
module tb_id_ex_stage;
  import riscv_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        uses1;
    logic        uses2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f75;
    logic [1:0]  alu;
    ex_ctrl_t    ctrl;
  } instr_t;

  typedef struct packed {
    logic        rst_n;
    logic        hold;
    logic        flush;
    instr_t      din;
    logic        exp_stall;
    instr_t      exp;
    logic [15:0] exp_scnt;
    logic [15:0] exp_fcnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, hold, flush;
  instr_t din;

  logic        ex_valid, ex_funct7_5, load_use_stall;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_alu_op;
  ex_ctrl_t    ex_ctrl;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_ex_valid, s_ex_funct7_5, s_load_use_stall;
  logic [31:0] s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
  logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic [2:0]  s_ex_funct3;
  logic [1:0]  s_ex_alu_op;
  ex_ctrl_t    s_ex_ctrl;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int check_count = 0;
  int error_count = 0;

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .id_valid(din.valid), .id_pc(din.pc), .id_rs1_data(din.rs1_data),
    .id_rs2_data(din.rs2_data), .id_imm(din.imm), .id_rs1(din.rs1), .id_rs2(din.rs2),
    .id_uses_rs1(din.uses1), .id_uses_rs2(din.uses2), .id_rd(din.rd),
    .id_funct3(din.f3), .id_funct7_5(din.f75), .id_alu_op(din.alu), .id_ctrl(din.ctrl),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7_5(ex_funct7_5),
    .ex_alu_op(ex_alu_op), .ex_ctrl(ex_ctrl), .load_use_stall(load_use_stall),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow counters make saturation reachable in a few dozen cycles
  id_ex_stage #(.XLEN(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .id_valid(din.valid), .id_pc(din.pc), .id_rs1_data(din.rs1_data),
    .id_rs2_data(din.rs2_data), .id_imm(din.imm), .id_rs1(din.rs1), .id_rs2(din.rs2),
    .id_uses_rs1(din.uses1), .id_uses_rs2(din.uses2), .id_rd(din.rd),
    .id_funct3(din.f3), .id_funct7_5(din.f75), .id_alu_op(din.alu), .id_ctrl(din.ctrl),
    .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_rs1_data(s_ex_rs1_data),
    .ex_rs2_data(s_ex_rs2_data), .ex_imm(s_ex_imm), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2),
    .ex_rd(s_ex_rd), .ex_funct3(s_ex_funct3), .ex_funct7_5(s_ex_funct7_5),
    .ex_alu_op(s_ex_alu_op), .ex_ctrl(s_ex_ctrl), .load_use_stall(s_load_use_stall),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  function automatic instr_t mk(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] imm,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic [2:0] f3, input logic f75, input logic [1:0] alu,
                                input logic [6:0] ctrl);
    instr_t r;
    r.valid = v; r.pc = pc; r.rs1_data = d1; r.rs2_data = d2; r.imm = imm;
    r.rs1 = rs1; r.rs2 = rs2; r.uses1 = u1; r.uses2 = u2; r.rd = rd;
    r.f3 = f3; r.f75 = f75; r.alu = alu; r.ctrl = ctrl;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic h, input logic f, input instr_t d);
    rst_n = r;
    hold  = h;
    flush = f;
    din   = d;
  endtask

  // Compares every EX output except uses1/uses2, which are not registered
  task automatic checkEx(input string tag, input instr_t e, input logic [15:0] sc, input logic [15:0] fc);
    checkOutput({tag, ".valid"},  32'(ex_valid),    32'(e.valid));
    checkOutput({tag, ".pc"},     ex_pc,            e.pc);
    checkOutput({tag, ".rs1d"},   ex_rs1_data,      e.rs1_data);
    checkOutput({tag, ".rs2d"},   ex_rs2_data,      e.rs2_data);
    checkOutput({tag, ".imm"},    ex_imm,           e.imm);
    checkOutput({tag, ".rs1"},    32'(ex_rs1),      32'(e.rs1));
    checkOutput({tag, ".rs2"},    32'(ex_rs2),      32'(e.rs2));
    checkOutput({tag, ".rd"},     32'(ex_rd),       32'(e.rd));
    checkOutput({tag, ".f3"},     32'(ex_funct3),   32'(e.f3));
    checkOutput({tag, ".f75"},    32'(ex_funct7_5), 32'(e.f75));
    checkOutput({tag, ".aluop"},  32'(ex_alu_op),   32'(e.alu));
    checkOutput({tag, ".ctrl"},   32'(ex_ctrl),     32'(e.ctrl));
    checkOutput({tag, ".scnt"},   32'(stall_cnt),   32'(sc));
    checkOutput({tag, ".fcnt"},   32'(flush_cnt),   32'(fc));
  endtask

  vec_t vecs[$];

  task automatic addVec(input logic r, input logic h, input logic f, input instr_t d,
                        input logic st, input instr_t e, input logic [15:0] sc, input logic [15:0] fc);
    vec_t v;
    v.rst_n = r; v.hold = h; v.flush = f; v.din = d;
    v.exp_stall = st; v.exp = e; v.exp_scnt = sc; v.exp_fcnt = fc;
    vecs.push_back(v);
  endtask

  initial begin
    instr_t BUB, ADD3, LW5, ADD6, ADD6I, LW0, ADD7, LW9, LUI10, SW5, BEQ, JAL, LWX, rnd;

    BUB   = '0;
    ADD3  = mk(1, 32'h100, 32'h11,   32'h22, 32'h0,        5'd1, 5'd2, 1, 1, 5'd3,  3'b000, 0, 2'b10, 7'b0001000);
    LW5   = mk(1, 32'h104, 32'h1000, 32'h33, 32'h8,        5'd1, 5'd8, 1, 0, 5'd5,  3'b010, 0, 2'b00, 7'b1101100);
    ADD6  = mk(1, 32'h108, 32'h55,   32'h66, 32'h0,        5'd5, 5'd1, 1, 1, 5'd6,  3'b000, 1, 2'b10, 7'b0001000);
    ADD6I = mk(0, 32'h108, 32'h55,   32'h66, 32'h0,        5'd5, 5'd1, 1, 1, 5'd6,  3'b000, 1, 2'b10, 7'b0001000);
    LW0   = mk(1, 32'h10C, 32'h2000, 32'h0,  32'h4,        5'd1, 5'd0, 1, 0, 5'd0,  3'b010, 0, 2'b00, 7'b1101100);
    ADD7  = mk(1, 32'h110, 32'h0,    32'h0,  32'h0,        5'd0, 5'd0, 1, 1, 5'd7,  3'b000, 0, 2'b10, 7'b0001000);
    LW9   = mk(1, 32'h114, 32'h3000, 32'h0,  32'hC,        5'd2, 5'd0, 1, 0, 5'd9,  3'b010, 0, 2'b00, 7'b1101100);
    LUI10 = mk(1, 32'h118, 32'h77,   32'h88, 32'h12345000, 5'd9, 5'd9, 0, 0, 5'd10, 3'b000, 0, 2'b00, 7'b1001000);
    SW5   = mk(1, 32'h120, 32'h4000, 32'h99, 32'h10,       5'd2, 5'd5, 1, 1, 5'd0,  3'b010, 0, 2'b00, 7'b1010000);
    BEQ   = mk(1, 32'h124, 32'hAA,   32'hBB, 32'hFFFFFFF0, 5'd1, 5'd2, 1, 1, 5'd0,  3'b000, 0, 2'b01, 7'b0000010);
    JAL   = mk(1, 32'h128, 32'h0,    32'h0,  32'h40,       5'd0, 5'd0, 0, 0, 5'd1,  3'b000, 0, 2'b00, 7'b0001001);
    LWX   = mk(1, 32'h130, 32'h5000, 32'h0,  32'h0,        5'd5, 5'd0, 1, 0, 5'd5,  3'b010, 0, 2'b00, 7'b1101100);

    //     rst hold flush din    stall expected-EX  stall_cnt flush_cnt
    addVec(1, 0, 0, ADD3,  0, ADD3,  0, 0);
    addVec(1, 0, 0, LW5,   0, LW5,   0, 0);
    addVec(1, 0, 0, ADD6,  1, BUB,   1, 0);
    addVec(1, 0, 0, ADD6,  0, ADD6,  1, 0);
    addVec(1, 0, 0, LW0,   0, LW0,   1, 0);
    addVec(1, 0, 0, ADD7,  0, ADD7,  1, 0);
    addVec(1, 0, 0, LW9,   0, LW9,   1, 0);
    addVec(1, 0, 0, LUI10, 0, LUI10, 1, 0);
    addVec(1, 0, 0, LW5,   0, LW5,   1, 0);
    addVec(1, 0, 0, SW5,   1, BUB,   2, 0);
    addVec(1, 0, 0, SW5,   0, SW5,   2, 0);
    addVec(1, 0, 0, LW5,   0, LW5,   2, 0);
    addVec(1, 0, 1, ADD6,  0, BUB,   2, 1);
    addVec(1, 0, 0, BEQ,   0, BEQ,   2, 1);
    addVec(1, 0, 0, LW5,   0, LW5,   2, 1);
    addVec(1, 0, 0, ADD6I, 0, ADD6I, 2, 1);
    addVec(1, 0, 0, LW5,   0, LW5,   2, 1);
    addVec(1, 1, 1, ADD6,  0, LW5,   2, 1);
    addVec(1, 1, 1, ADD6,  0, LW5,   2, 1);
    addVec(1, 1, 1, ADD6,  0, LW5,   2, 1);
    addVec(1, 0, 1, ADD6,  0, BUB,   2, 2);
    addVec(1, 0, 0, LW5,   0, LW5,   2, 2);
    addVec(1, 1, 0, ADD6,  1, LW5,   2, 2);
    addVec(1, 0, 0, ADD6,  1, BUB,   3, 2);
    addVec(1, 0, 0, ADD6,  0, ADD6,  3, 2);
    addVec(1, 0, 0, JAL,   0, JAL,   3, 2);
    addVec(0, 1, 0, LW5,   0, BUB,   0, 0);

    // Reset with arbitrary ID contents
    rnd = mk(1'($urandom), $urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
             1'($urandom), 1'($urandom), 5'($urandom), 3'($urandom), 1'($urandom),
             2'($urandom_range(0, 2)), 7'($urandom));
    applyStimulus(0, 1'($urandom), 1'($urandom), rnd);
    repeat (2) @(posedge clk);
    #1;
    checkEx("reset", BUB, 16'd0, 16'd0);
    checkOutput("reset.stall", 32'(load_use_stall), 32'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].hold, vecs[i].flush, vecs[i].din);
      #1;
      checkOutput($sformatf("r%0d.stall", i), 32'(load_use_stall), 32'(vecs[i].exp_stall));
      @(posedge clk);
      #1;
      checkEx($sformatf("r%0d", i), vecs[i].exp, vecs[i].exp_scnt, vecs[i].exp_fcnt);
    end

    // Self-dependent load: hazard on every other edge, 20 hazards in 40 edges
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 0, 0, LWX);
      #1;
      checkOutput($sformatf("sat%0d.stall", i), 32'(load_use_stall), 32'(i % 2));
      @(posedge clk);
      #1;
    end
    checkOutput("sat.scnt_wide",   32'(stall_cnt),   32'd20);
    checkOutput("sat.scnt_narrow", 32'(s_stall_cnt), 32'd15);
    checkOutput("sat.fcnt_narrow", 32'(s_flush_cnt), 32'd0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 1, LWX);
      @(posedge clk);
      #1;
    end
    checkOutput("satf.fcnt_wide",   32'(flush_cnt),   32'd20);
    checkOutput("satf.fcnt_narrow", 32'(s_flush_cnt), 32'd15);
    checkOutput("satf.scnt_narrow", 32'(s_stall_cnt), 32'd15);
    checkOutput("satf.valid",       32'(ex_valid),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
